// File: rtl/dcache.sv
// dcache: direct-mapped data cache, 16-byte lines, hit resolved combinationally.
// Write-through by default; define CACHE_WRITEBACK_EN for write-back with per-line dirty bits.
module dcache #(
  parameter int unsigned LINES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  input  logic         memread,
  input  logic         memwrite,
  output logic [31:0]  rdata,
  output logic         stall,
  output logic [31:0]  mem_addr,
  input  logic [127:0] mem_rdata,
  output logic [127:0] mem_wdata,
  output logic         mem_read,
  output logic         mem_write,
  input  logic         mem_ready
);
  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = 28 - IdxW;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFill  = 2'd2;
`ifdef CACHE_WRITEBACK_EN
  localparam logic [1:0] StWback = 2'd1;
`else
  localparam logic [1:0] StWthru = 2'd3;
`endif

  logic [1:0]       r_state;
  logic [1:0]       w_state_d;
  logic [127:0]     r_data [LINES];
  logic [TagW-1:0]  r_tag  [LINES];
  logic [LINES-1:0] r_valid;

  logic [IdxW-1:0]  w_idx;
  logic [TagW-1:0]  w_tag;
  logic [1:0]       w_word;
  logic             w_req;
  logic             w_hit;
  logic             w_fill_we;
  logic             w_store_we;
  logic             w_unused;
  logic [127:0]     w_line;
  logic [127:0]     w_store_line;

  assign w_idx    = addr[4 +: IdxW];
  assign w_tag    = addr[31 -: TagW];
  assign w_word   = addr[3:2];
  assign w_unused = ^addr[1:0];
  assign w_req    = memread | memwrite;
  assign w_line   = r_data[w_idx];
  assign w_hit    = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);

  always_comb begin
    w_store_line = w_line;
    w_store_line[{w_word, 5'd0} +: 32] = wdata;
  end

`ifdef CACHE_WRITEBACK_EN
  logic [LINES-1:0] r_dirty;
  logic             w_victim_dirty;
  assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];
`endif

  always_comb begin
    w_state_d  = r_state;
    stall      = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = {addr[31:4], 4'd0};
    mem_wdata  = w_line;
    w_fill_we  = 1'b0;
    w_store_we = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_hit) begin
          w_store_we = memwrite;
`ifndef CACHE_WRITEBACK_EN
          // A store is only complete once the updated line has reached memory.
          if (memwrite) begin
            stall     = 1'b1;
            w_state_d = StWthru;
          end
`endif
        end else if (w_req) begin
          stall = 1'b1;
`ifdef CACHE_WRITEBACK_EN
          w_state_d = w_victim_dirty ? StWback : StFill;
`else
          w_state_d = StFill;
`endif
        end
      end
`ifdef CACHE_WRITEBACK_EN
      StWback: begin
        stall     = 1'b1;
        mem_write = 1'b1;
        mem_addr  = {r_tag[w_idx], w_idx, 4'd0};
        if (mem_ready) w_state_d = StFill;
      end
`else
      StWthru: begin
        mem_write = 1'b1;
        stall     = ~mem_ready;
        if (mem_ready) w_state_d = StIdle;
      end
`endif
      StFill: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          w_fill_we = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign rdata = (r_state == StIdle && w_hit && !memwrite) ? w_line[{w_word, 5'd0} +: 32]
                                                           : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_valid <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_fill_we) r_valid[w_idx] <= 1'b1;
    end
  end

  // Gated by reset so an aborted transfer never lands in the arrays.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_fill_we) begin
        r_data[w_idx] <= mem_rdata;
        r_tag[w_idx]  <= w_tag;
      end else if (w_store_we) begin
        r_data[w_idx] <= w_store_line;
      end
    end
  end

`ifdef CACHE_WRITEBACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dirty <= '0;
    end else if (w_fill_we) begin
      r_dirty[w_idx] <= 1'b0;
    end else if (w_store_we) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed stimulus with a scoreboard queue; a monitor pops on every memory
// transfer completion and every CPU request completion. Handles both CACHE_WRITEBACK_EN builds.
module tb_dcache;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic         memread;
  logic         memwrite;
  logic [31:0]  rdata;
  logic         stall;
  logic [31:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic [127:0] mem_wdata;
  logic         mem_read;
  logic         mem_write;
  logic         mem_ready;

  logic r_auto = 1'b0;
  logic man_ready = 1'b0;
  logic auto_ready = 1'b1;
  int   ready_delay = 0;
  assign mem_ready = auto_ready ? r_auto : man_ready;

  localparam logic [127:0] L40  = 128'h33333333_22222222_11111111_DEADBEEF;
  localparam logic [127:0] L80  = 128'h80808083_80808082_80808081_80808080;
  localparam logic [127:0] LFF  = 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0;
  localparam logic [127:0] L40B = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_0F0F0F0F;
`ifdef CACHE_WRITEBACK_EN
  localparam logic [127:0] L40_WB = 128'h33333333_22222222_11111111_A5A5A5A5;
  localparam logic [127:0] L140   = 128'h44444444_55555555_66666666_77777777;
`else
  localparam logic [127:0] L40_WT = 128'h33333333_22222222_12345678_DEADBEEF;
  localparam logic [127:0] L80_S1 = 128'h80808083_80808082_CAFEF00D_80808080;
  localparam logic [127:0] L80_S2 = 128'h80808083_0BADCAFE_CAFEF00D_80808080;
`endif

  // kind: 0 = CPU request completes, 1 = memory read done, 2 = memory write done
  typedef struct {
    int           kind;
    logic [31:0]  a;
    logic [127:0] d;
    int           stalls;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  dcache #(.LINES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .memread   (memread),
    .memwrite  (memwrite),
    .rdata     (rdata),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] a, input logic [127:0] d,
                           input int stalls);
    ev_t e;
    e.kind   = kind;
    e.a      = a;
    e.d      = d;
    e.stalls = stalls;
    exp_q.push_back(e);
  endtask

  task automatic compare_ev(input int kind, input logic [31:0] a, input logic [127:0] d,
                            input int stalls);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h stalls=%0d, required none",
               kind, a, d, stalls);
    end else begin
      e = exp_q.pop_front();
      if (kind != e.kind || a !== e.a || d !== e.d || stalls != e.stalls) begin
        fails++;
        $display("FAIL event: got kind=%0d addr=%h data=%h stalls=%0d, required kind=%0d addr=%h data=%h stalls=%0d",
                 kind, a, d, stalls, e.kind, e.a, e.d, e.stalls);
      end
    end
  endtask

  // Backing memory: pulse mem_ready after ready_delay extra strobe cycles.
  initial begin
    int wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if ((mem_read || mem_write) && !r_auto) begin
        if (wait_cnt >= ready_delay) begin
          r_auto   = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        r_auto   = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    int   stall_cnt = 0;
    logic prev_rd_done = 1'b0;
    logic prev_wr_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_cnt    = 0;
        prev_rd_done = 1'b0;
        prev_wr_done = 1'b0;
      end else begin
        if (prev_rd_done) check("rd_deassert", {127'd0, mem_read}, 128'd0);
        if (prev_wr_done) check("wr_deassert", {127'd0, mem_write}, 128'd0);
        if (mem_read || mem_write) check("one_strobe", {127'd0, mem_read & mem_write}, 128'd0);
        if ((mem_read || mem_write) && mem_ready)
          compare_ev(mem_write ? 2 : 1, mem_addr, mem_write ? mem_wdata : 128'd0, 0);
        prev_rd_done = mem_read && mem_ready;
        prev_wr_done = mem_write && mem_ready;
        if (memread || memwrite) begin
          if (stall) begin
            stall_cnt++;
          end else begin
            compare_ev(0, addr, {96'd0, rdata}, stall_cnt);
            stall_cnt = 0;
          end
        end else begin
          check("idle_rdata", {96'd0, rdata}, 128'd0);
          stall_cnt = 0;
        end
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d);
    bit done = 1'b0;
    @(posedge clk);
    #1;
    memread  = rd;
    memwrite = wr;
    addr     = a;
    wdata    = d;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: stall still 1 after 40 cycles at addr %h, required 0", a);
    end
    @(posedge clk);
    #1;
    memread  = 1'b0;
    memwrite = 1'b0;
  endtask

  initial begin
    memread   = 1'b0;
    memwrite  = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;
    mem_rdata = 128'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_stall", {127'd0, stall}, 128'd0);
    check("rst_rdata", {96'd0, rdata}, 128'd0);
    check("rst_mem_read", {127'd0, mem_read}, 128'd0);
    check("rst_mem_write", {127'd0, mem_write}, 128'd0);

    // Cold load miss, memory answers on the first FILL cycle.
    mem_rdata = L40;
    expect_ev(1, 32'h40, 128'd0, 0);
    expect_ev(0, 32'h40, 128'hDEADBEEF, 2);
    do_req(1'b1, 1'b0, 32'h40, 32'd0);

    expect_ev(0, 32'h4C, 128'h33333333, 0);
    do_req(1'b1, 1'b0, 32'h4C, 32'd0);

`ifndef CACHE_WRITEBACK_EN
    ready_delay = 2;
    expect_ev(2, 32'h40, L40_WT, 0);
    expect_ev(0, 32'h44, 128'd0, 3);
    do_req(1'b0, 1'b1, 32'h44, 32'h12345678);
    ready_delay = 0;
    expect_ev(0, 32'h44, 128'h12345678, 0);
    do_req(1'b1, 1'b0, 32'h44, 32'd0);

    mem_rdata = L80;
    expect_ev(1, 32'h80, 128'd0, 0);
    expect_ev(2, 32'h80, L80_S1, 0);
    expect_ev(0, 32'h84, 128'd0, 3);
    do_req(1'b0, 1'b1, 32'h84, 32'hCAFEF00D);
    expect_ev(0, 32'h84, 128'hCAFEF00D, 0);
    do_req(1'b1, 1'b0, 32'h84, 32'd0);

    expect_ev(2, 32'h80, L80_S2, 0);
    expect_ev(0, 32'h88, 128'd0, 1);
    do_req(1'b1, 1'b1, 32'h88, 32'h0BADCAFE);
`else
    expect_ev(0, 32'h40, 128'd0, 0);
    do_req(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5);

    mem_rdata = L140;
    expect_ev(2, 32'h40, L40_WB, 0);
    expect_ev(1, 32'h140, 128'd0, 0);
    expect_ev(0, 32'h140, 128'h77777777, 4);
    do_req(1'b1, 1'b0, 32'h140, 32'd0);

    mem_rdata = L80;
    expect_ev(1, 32'h80, 128'd0, 0);
    expect_ev(0, 32'h84, 128'd0, 2);
    do_req(1'b0, 1'b1, 32'h84, 32'hCAFEF00D);
    expect_ev(0, 32'h84, 128'hCAFEF00D, 0);
    do_req(1'b1, 1'b0, 32'h84, 32'd0);

    expect_ev(0, 32'h88, 128'd0, 0);
    do_req(1'b1, 1'b1, 32'h88, 32'h0BADCAFE);
`endif
    expect_ev(0, 32'h88, 128'h0BADCAFE, 0);
    do_req(1'b1, 1'b0, 32'h88, 32'd0);

    // Top index with an all-ones tag, one wait cycle on the fill.
    mem_rdata   = LFF;
    ready_delay = 1;
    expect_ev(1, 32'hFFFFFFF0, 128'd0, 0);
    expect_ev(0, 32'hFFFFFFFC, 128'hF3F3F3F3, 3);
    do_req(1'b1, 1'b0, 32'hFFFFFFFC, 32'd0);
    ready_delay = 0;

    // Abort a fill with reset, then present a stray mem_ready.
    auto_ready = 1'b0;
    @(posedge clk);
    #1;
    memread = 1'b1;
    addr    = 32'h240;
    @(negedge clk);
    check("abort_miss_stall", {127'd0, stall}, 128'd1);
    @(posedge clk);
    @(negedge clk);
    check("abort_fill_read", {127'd0, mem_read}, 128'd1);
    check("abort_fill_addr", {96'd0, mem_addr}, 128'h240);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    memread = 1'b0;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    man_ready = 1'b1;
    @(negedge clk);
    check("abort_mem_read", {127'd0, mem_read}, 128'd0);
    check("abort_mem_write", {127'd0, mem_write}, 128'd0);
    check("abort_stall", {127'd0, stall}, 128'd0);
    @(posedge clk);
    #1;
    man_ready  = 1'b0;
    auto_ready = 1'b1;

    mem_rdata = L40B;
    expect_ev(1, 32'h40, 128'd0, 0);
    expect_ev(0, 32'h40, 128'h0F0F0F0F, 2);
    do_req(1'b1, 1'b0, 32'h40, 32'd0);
    expect_ev(0, 32'h44, 128'hA1A1A1A1, 0);
    do_req(1'b1, 1'b0, 32'h44, 32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
